cyber_press_gen: RTL and testbench
==================================

CYBER_PRESS_GEN -- requirements
Module: cyber_press_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 10, random/threshold word width; only 10 is supported because the taps are fixed.
REQ-002 SHALL have parameter COOLDOWN, default 4, number of cooldown cycles after each acknowledged press (range 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, run enable.
REQ-006 SHALL have port threshold, input, WIDTH, unsigned press threshold (switch value).
REQ-007 SHALL have port ack, input, 1, consumer acknowledge of press.
REQ-008 SHALL have port press, output, 1, registered press request.
REQ-009 SHALL have port rnd, output, WIDTH, current LFSR value.
REQ-010 SHALL have port busy, output, 1, high in PRESS or COOL.

Function
REQ-011 SHALL implement a WIDTH-bit Fibonacci LFSR:
- shift left; new bit 0 = ~(rnd[9] ^ rnd[6]) (XNOR feedback).
- maximal length 1023; the all-ones value is the lockup state and never occurs from reset.
REQ-012 SHALL be an FSM with states IDLE, RUN, PRESS, COOL; its encoding is internal.
REQ-013 IDLE:
- LFSR holds; press=0.
- en=1 -> RUN on next edge.
REQ-014 RUN:
- LFSR steps every cycle.
- threshold > rnd (strict, unsigned, compared on the current registered rnd) -> PRESS on the same edge; the LFSR still steps on that edge.
- otherwise en=0 -> IDLE.
- The press condition has priority over en=0.
REQ-015 PRESS:
- press=1; LFSR holds.
- Stays in PRESS until ack=1, even if en drops, so no request is abandoned.
- ack=1 -> COOL with the counter loaded to COOLDOWN-1.
REQ-016 COOL:
- LFSR steps; press=0.
- Counter decrements each cycle.
- At 0: en=1 -> RUN, en=0 -> IDLE.
REQ-017 Latency: press rises exactly 1 cycle after the RUN cycle in which threshold > rnd; press falls on the edge where ack is sampled high.
REQ-018 ack outside PRESS SHALL be ignored.
REQ-019 Boundaries:
- threshold=0 never presses.
- threshold=1023 presses on every RUN cycle, since rnd is never 1023.
- A threshold change takes effect in the same cycle it is presented.

Reset
REQ-020 reset_n=0 SHALL immediately, independent of clk:
- set state to IDLE and rnd to 0;
- clear the cooldown counter;
- drive press=0 and busy=0.
REQ-021 Reset mid-PRESS or mid-COOL SHALL abandon the request with no residual state; the first step after release yields rnd=1.

Configuration
REQ-022 Macro CYBER_SEED_LOAD_EN SHALL control seed loading.
- Defined: adds inputs seed_load (1) and seed (WIDTH).
- seed_load=1 in any state loads rnd <= seed and overrides the step; a seed of all-ones loads 0.
- The state is unaffected by a seed load.
REQ-023 Without CYBER_SEED_LOAD_EN the ports SHALL be absent, and the LFSR is reachable only from reset value 0.

Verification
REQ-024 Reset, then en=1, threshold=0 -> rnd sequence 0,1,3,7,15,...; press stays 0 for 1100 cycles; no value 1023.
REQ-025 threshold=1023, en=1, ack=0 -> press=1 one cycle after the first RUN cycle; press and rnd stay frozen for 20 cycles.
REQ-026 In PRESS, pulse ack for 1 cycle, COOLDOWN=4 -> press=0 next edge; busy=1 for exactly 4 COOL cycles; then RUN.
REQ-027 In PRESS, drop en=0 and then ack=1 -> COOL, then IDLE; rnd holds in IDLE.
REQ-028 Assert reset_n=0 mid-COOL between clock edges -> press=0, rnd=0, busy=0 before the next edge.
REQ-029 With CYBER_SEED_LOAD_EN: seed=10'h3FF, seed_load=1 -> rnd=0; seed=10'h155 -> rnd=10'h155, then the next step gives 10'h2AA.

Source files
------------

// File: rtl/cyber_press_gen.sv
// Random press generator: 10-bit XNOR LFSR compared against a threshold, with a press/ack/cooldown FSM.
// Optional seed loading is enabled by defining CYBER_SEED_LOAD_EN.
module cyber_press_gen #(
   parameter int WIDTH    = 10,
   parameter int COOLDOWN = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic [WIDTH-1:0] threshold,
   input  logic             ack,
`ifdef CYBER_SEED_LOAD_EN
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
`endif
   output logic             press,
   output logic [WIDTH-1:0] rnd,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PRESS = 2'd2,
      COOL  = 2'd3
   } state_t;

   localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rnd_q, rnd_d;
   logic [WIDTH-1:0] rnd_step;
   logic [7:0]       cnt_q, cnt_d;
   logic             press_q, press_d;

   // Taps 10 and 7 with XNOR feedback: all-ones is the lockup value, zero is a legal start.
   assign rnd_step = {rnd_q[WIDTH-2:0], ~(rnd_q[9] ^ rnd_q[6])};

   always_comb begin
      state_d = state_q;
      rnd_d   = rnd_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (en) state_d = RUN;
         end
         RUN: begin
            rnd_d = rnd_step;
            if (threshold > rnd_q) state_d = PRESS;
            else if (!en)          state_d = IDLE;
         end
         PRESS: begin
            if (ack) begin
               state_d = COOL;
               cnt_d   = COOL_LOAD;
            end
         end
         COOL: begin
            rnd_d = rnd_step;
            if (cnt_q == 8'd0) state_d = en ? RUN : IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
`ifdef CYBER_SEED_LOAD_EN
      // A seed overrides the step but never the FSM; the lockup value is mapped to zero.
      if (seed_load) rnd_d = (seed == {WIDTH{1'b1}}) ? '0 : seed;
`endif
      press_d = (state_d == PRESS);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rnd_q   <= '0;
         cnt_q   <= 8'd0;
         press_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rnd_q   <= rnd_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press     = press_q;
   assign rnd       = rnd_q;
   assign busy      = (state_q == PRESS) || (state_q == COOL);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_cyber_press_gen.sv
// Directed bench for cyber_press_gen: vector table plus hand sequences for lockup, freeze,
// async reset and (when CYBER_SEED_LOAD_EN is defined) seed loading.
module tb_cyber_press_gen;

   logic       clk;
   logic       reset_n;
   logic       en;
   logic [9:0] threshold;
   logic       ack;
   logic       press;
   logic [9:0] rnd;
   logic       busy;
   logic [1:0] dbg_state;
`ifdef CYBER_SEED_LOAD_EN
   logic       seed_load;
   logic [9:0] seed;
`endif

   int vectors;
   int miscompares;

   cyber_press_gen #(.WIDTH(10), .COOLDOWN(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .en        (en),
      .threshold (threshold),
      .ack       (ack),
`ifdef CYBER_SEED_LOAD_EN
      .seed_load (seed_load),
      .seed      (seed),
`endif
      .press     (press),
      .rnd       (rnd),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [9:0] thr;
      logic       ack;
      logic       exp_press;
      logic       exp_busy;
      logic [9:0] exp_rnd;
   } vec_t;

   vec_t vecs[23];

   function automatic logic [9:0] lfsr_next(input logic [9:0] v);
      return {v[8:0], ~(v[9] ^ v[6])};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      en        = 1'b0;
      ack       = 1'b0;
      threshold = 10'd0;
`ifdef CYBER_SEED_LOAD_EN
      seed_load = 1'b0;
      seed      = 10'd0;
`endif
      repeat (2) tick();
      reset_n = 1'b1;
   endtask

   initial begin
      logic [9:0] model;
      logic [9:0] frozen;
      int         seq_bad;
      int         press_seen;
      int         lockup_seen;
      int         first_zero;
      int         frozen_bad;

      vectors     = 0;
      miscompares = 0;

      //             en  thr       ack press busy rnd
      vecs[0]  = '{1'b0, 10'd0,    1'b0, 1'b0, 1'b0, 10'd0};
      vecs[1]  = '{1'b1, 10'd0,    1'b0, 1'b0, 1'b0, 10'd0};
      vecs[2]  = '{1'b1, 10'd0,    1'b0, 1'b0, 1'b0, 10'd1};
      vecs[3]  = '{1'b1, 10'd0,    1'b0, 1'b0, 1'b0, 10'd3};
      vecs[4]  = '{1'b1, 10'd0,    1'b0, 1'b0, 1'b0, 10'd7};
      vecs[5]  = '{1'b1, 10'd8,    1'b0, 1'b1, 1'b1, 10'd15};
      vecs[6]  = '{1'b1, 10'd0,    1'b0, 1'b1, 1'b1, 10'd15};
      vecs[7]  = '{1'b0, 10'd0,    1'b0, 1'b1, 1'b1, 10'd15};
      vecs[8]  = '{1'b0, 10'd0,    1'b1, 1'b0, 1'b1, 10'd15};
      vecs[9]  = '{1'b0, 10'd0,    1'b0, 1'b0, 1'b1, 10'd31};
      vecs[10] = '{1'b0, 10'd0,    1'b0, 1'b0, 1'b1, 10'd63};
      vecs[11] = '{1'b0, 10'd0,    1'b0, 1'b0, 1'b1, 10'd127};
      vecs[12] = '{1'b0, 10'd0,    1'b0, 1'b0, 1'b0, 10'd254};
      vecs[13] = '{1'b0, 10'd0,    1'b0, 1'b0, 1'b0, 10'd254};
      vecs[14] = '{1'b1, 10'd0,    1'b1, 1'b0, 1'b0, 10'd254};
      vecs[15] = '{1'b1, 10'd1023, 1'b0, 1'b1, 1'b1, 10'd508};
      vecs[16] = '{1'b1, 10'd0,    1'b1, 1'b0, 1'b1, 10'd508};
      vecs[17] = '{1'b1, 10'd0,    1'b0, 1'b0, 1'b1, 10'd1016};
      vecs[18] = '{1'b1, 10'd0,    1'b0, 1'b0, 1'b1, 10'd1009};
      vecs[19] = '{1'b1, 10'd0,    1'b0, 1'b0, 1'b1, 10'd995};
      vecs[20] = '{1'b1, 10'd0,    1'b0, 1'b0, 1'b0, 10'd967};
      vecs[21] = '{1'b1, 10'd967,  1'b0, 1'b0, 1'b0, 10'd911};
      vecs[22] = '{1'b1, 10'd912,  1'b0, 1'b1, 1'b1, 10'd798};

      // reset state
      do_reset();
      check("reset_press", 32'(press), 32'd0);
      check("reset_busy",  32'(busy),  32'd0);
      check("reset_rnd",   32'(rnd),   32'd0);

      // table
      for (int i = 0; i < 23; i++) begin
         en        = vecs[i].en;
         threshold = vecs[i].thr;
         ack       = vecs[i].ack;
         tick();
         check($sformatf("vec%0d_press", i), 32'(press), 32'(vecs[i].exp_press));
         check($sformatf("vec%0d_busy", i),  32'(busy),  32'(vecs[i].exp_busy));
         check($sformatf("vec%0d_rnd", i),   32'(rnd),   32'(vecs[i].exp_rnd));
      end

      // threshold 0: full-period walk, never presses, never hits lockup
      do_reset();
      en = 1'b1;
      tick();
      check("zero_first_rnd", 32'(rnd), 32'd0);
      model       = 10'd0;
      seq_bad     = 0;
      press_seen  = 0;
      lockup_seen = 0;
      first_zero  = 0;
      for (int k = 1; k <= 1100; k++) begin
         tick();
         model = lfsr_next(model);
         if (rnd !== model) seq_bad++;
         if (press !== 1'b0) press_seen++;
         if (rnd == 10'h3FF) lockup_seen++;
         if (rnd == 10'd0 && first_zero == 0) first_zero = k;
      end
      check("zero_rnd_sequence", 32'(seq_bad),     32'd0);
      check("zero_no_press",     32'(press_seen),  32'd0);
      check("zero_no_lockup",    32'(lockup_seen), 32'd0);
      check("zero_period",       32'(first_zero),  32'd1023);

      // threshold 1023: press after first RUN cycle, then frozen without ack
      do_reset();
      en        = 1'b1;
      threshold = 10'd1023;
      tick();
      check("max_run_press", 32'(press), 32'd0);
      check("max_run_rnd",   32'(rnd),   32'd0);
      tick();
      check("max_press",     32'(press), 32'd1);
      check("max_press_rnd", 32'(rnd),   32'd1);
      frozen     = rnd;
      frozen_bad = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (press !== 1'b1 || rnd !== frozen) frozen_bad++;
      end
      check("max_frozen", 32'(frozen_bad), 32'd0);

      // ack pulse into COOL, then asynchronous reset between edges
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("cool_press", 32'(press), 32'd0);
      check("cool_busy",  32'(busy),  32'd1);
      check("cool_rnd",   32'(rnd),   32'd1);
      tick();
      check("cool2_rnd",  32'(rnd),   32'd3);
      check("cool2_busy", 32'(busy),  32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("areset_press", 32'(press), 32'd0);
      check("areset_rnd",   32'(rnd),   32'd0);
      check("areset_busy",  32'(busy),  32'd0);
      #2;
      reset_n   = 1'b1;
      threshold = 10'd0;
      tick();
      check("post_reset_run_rnd",  32'(rnd), 32'd0);
      tick();
      check("post_reset_step_rnd", 32'(rnd), 32'd1);

`ifdef CYBER_SEED_LOAD_EN
      seed_load = 1'b1;
      seed      = 10'h3FF;
      tick();
      check("seed_lockup_rnd", 32'(rnd), 32'h000);
      seed = 10'h155;
      tick();
      check("seed_load_rnd", 32'(rnd), 32'h155);
      seed_load = 1'b0;
      tick();
      check("seed_step_rnd", 32'(rnd), 32'h2AA);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
